equiv_result_monitor: RTL and testbench

- Clocked stage directly downstream of a spec/impl pair of `dut` instances in the define2 equivalence systest.
- Accepts one stimulus vector {a,n1,n2} at a time, waits a settle interval, then compares each of the five 4-bit spec/impl outputs with 4-state case-inequality.
- Keeps pass/fail statistics and captures the first failing vector.
- Replaces the unclocked per-vector `#10`/`$display` checking with a reusable, self-terminating monitor.

---
 rtl/equiv_cmp_pkg.sv | 23 ++
 rtl/out_case_diff.sv | 18 +
 rtl/equiv_result_monitor.sv | 163 ++++++++++++++++
 tb/tb_equiv_result_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/equiv_cmp_pkg.sv
// Shared constants, stimulus layout and FSM states for the spec/impl equivalence monitor.
package equiv_cmp_pkg;

  localparam int NUM_OUTS = 5;
  localparam int OUT_W    = 4;
  localparam int VEC_W    = 12;
  localparam int OUTS_W   = NUM_OUTS * OUT_W;

  // Field order mirrors how the vector is driven onto both dut instances.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] n1;
    logic [3:0] n2;
  } stim_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/out_case_diff.sv
// Per-output 4-state case-inequality between the spec and impl result buses.
module out_case_diff
  import equiv_cmp_pkg::*;
(
  input  logic [OUTS_W-1:0]   spec_i,
  input  logic [OUTS_W-1:0]   impl_i,
  output logic [NUM_OUTS-1:0] mask_o
);

  // Any x/z difference flags a mismatch, exactly as a === check would.
  always_comb begin
    mask_o = '0;
    for (int k = 0; k < NUM_OUTS; k++) begin
      mask_o[k] = (impl_i[k*OUT_W +: OUT_W] !== spec_i[k*OUT_W +: OUT_W]);
    end
  end

endmodule

// File: rtl/equiv_result_monitor.sv
// Accepts one stimulus vector at a time, waits for the duts to settle, compares
// their outputs, and keeps pass/fail statistics plus the first failing vector.
module equiv_result_monitor
  import equiv_cmp_pkg::*;
#(
  parameter int          SETTLE   = 2,
  parameter int unsigned NUM_VECS = 1000000,
  parameter int          CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [VEC_W-1:0]    vec,
  input  logic [OUTS_W-1:0]   spec_o,
  input  logic [OUTS_W-1:0]   impl_o,
  output logic                chk_valid,
  output logic                chk_ok,
  output logic [NUM_OUTS-1:0] chk_mask,
  output logic [CNT_W-1:0]    vec_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic [VEC_W-1:0]    first_fail_vec,
  output logic [NUM_OUTS-1:0] first_fail_mask,
  output logic                any_fail,
  output logic                done
);

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LAST_VEC    = CNT_W'(NUM_VECS);

  state_t              state_q, state_d;
  logic [3:0]          settle_cnt_q, settle_cnt_d;
  stim_t               vec_q, vec_d;
  logic                vec_ready_q, vec_ready_d;
  logic                chk_valid_q, chk_valid_d;
  logic                chk_ok_q, chk_ok_d;
  logic [NUM_OUTS-1:0] chk_mask_q, chk_mask_d;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic [VEC_W-1:0]    ff_vec_q, ff_vec_d;
  logic [NUM_OUTS-1:0] ff_mask_q, ff_mask_d;
  logic                any_fail_q, any_fail_d;
  logic                done_q, done_d;

  logic [NUM_OUTS-1:0] mask;
  logic [CNT_W-1:0]    vec_inc;

  out_case_diff u_diff (
    .spec_i (spec_o),
    .impl_i (impl_o),
    .mask_o (mask)
  );

  assign vec_inc = vec_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    vec_d        = vec_q;
    chk_valid_d  = 1'b0;
    chk_ok_d     = chk_ok_q;
    chk_mask_d   = chk_mask_q;
    vec_cnt_d    = vec_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    ff_vec_d     = ff_vec_q;
    ff_mask_d    = ff_mask_q;
    any_fail_d   = any_fail_q;
    done_d       = done_q;

    case (state_q)
      S_IDLE: begin
        if (vec_valid && vec_ready_q) begin
          vec_d        = stim_t'(vec);
          settle_cnt_d = SETTLE_INIT;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        chk_valid_d = 1'b1;
        chk_mask_d  = mask;
        chk_ok_d    = (mask == '0);
        vec_cnt_d   = vec_inc;
        if (mask != '0) begin
          if (fail_cnt_q != '1) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end
          // Only the first failure is kept for debug; later ones just count.
          if (!any_fail_q) begin
            ff_vec_d   = vec_q;
            ff_mask_d  = mask;
            any_fail_d = 1'b1;
          end
        end
        if (vec_inc == LAST_VEC) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    vec_ready_d = (state_d == S_IDLE);
  end

  // Registered ready keeps it low while reset is held and for the first cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 4'd0;
      vec_q        <= '0;
      vec_ready_q  <= 1'b0;
      chk_valid_q  <= 1'b0;
      chk_ok_q     <= 1'b0;
      chk_mask_q   <= '0;
      vec_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      ff_vec_q     <= '0;
      ff_mask_q    <= '0;
      any_fail_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      vec_q        <= vec_d;
      vec_ready_q  <= vec_ready_d;
      chk_valid_q  <= chk_valid_d;
      chk_ok_q     <= chk_ok_d;
      chk_mask_q   <= chk_mask_d;
      vec_cnt_q    <= vec_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      ff_vec_q     <= ff_vec_d;
      ff_mask_q    <= ff_mask_d;
      any_fail_q   <= any_fail_d;
      done_q       <= done_d;
    end
  end

  assign vec_ready       = vec_ready_q;
  assign chk_valid       = chk_valid_q;
  assign chk_ok          = chk_ok_q;
  assign chk_mask        = chk_mask_q;
  assign vec_cnt         = vec_cnt_q;
  assign fail_cnt        = fail_cnt_q;
  assign first_fail_vec  = ff_vec_q;
  assign first_fail_mask = ff_mask_q;
  assign any_fail        = any_fail_q;
  assign done            = done_q;

endmodule

// File: tb/tb_equiv_result_monitor.sv
// Directed bench: a long-running monitor for compare behaviour and a NUM_VECS=3
// monitor for termination, both driven from one linear stimulus sequence.
module tb_equiv_result_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        vecValid;
  logic        termValid;
  logic [11:0] vec;
  logic [19:0] specO;
  logic [19:0] implO;

  logic        vecReady, chkValid, chkOk, anyFail, done;
  logic [4:0]  chkMask, firstFailMask;
  logic [31:0] vecCnt, failCnt;
  logic [11:0] firstFailVec;

  logic        tVecReady, tChkValid, tChkOk, tAnyFail, tDone;
  logic [4:0]  tChkMask, tFirstFailMask;
  logic [31:0] tVecCnt, tFailCnt;
  logic [11:0] tFirstFailVec;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  equiv_result_monitor #(.SETTLE(2), .NUM_VECS(1000), .CNT_W(32)) dutMain (
    .clk(clk), .reset(reset), .vec_valid(vecValid), .vec_ready(vecReady),
    .vec(vec), .spec_o(specO), .impl_o(implO),
    .chk_valid(chkValid), .chk_ok(chkOk), .chk_mask(chkMask),
    .vec_cnt(vecCnt), .fail_cnt(failCnt),
    .first_fail_vec(firstFailVec), .first_fail_mask(firstFailMask),
    .any_fail(anyFail), .done(done)
  );

  equiv_result_monitor #(.SETTLE(2), .NUM_VECS(3), .CNT_W(32)) dutTerm (
    .clk(clk), .reset(reset), .vec_valid(termValid), .vec_ready(tVecReady),
    .vec(vec), .spec_o(specO), .impl_o(implO),
    .chk_valid(tChkValid), .chk_ok(tChkOk), .chk_mask(tChkMask),
    .vec_cnt(tVecCnt), .fail_cnt(tFailCnt),
    .first_fail_vec(tFirstFailVec), .first_fail_mask(tFirstFailMask),
    .any_fail(tAnyFail), .done(tDone)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference case-inequality, used where the driven operands carry x bits.
  function automatic logic [4:0] expMask(input logic [19:0] s, input logic [19:0] i);
    logic [4:0] m;
    m = '0;
    for (int k = 0; k < 5; k++) m[k] = (s[k*4 +: 4] !== i[k*4 +: 4]);
    return m;
  endfunction

  // Presents one vector, completes the handshake and waits for its result pulse.
  task automatic applyStimulus(input logic [11:0] v, input logic [19:0] s,
                               input logic [19:0] i, output int latency);
    int waitCnt;
    vec = v; specO = s; implO = i; vecValid = 1'b1;
    waitCnt = 0;
    while (vecReady !== 1'b1 && waitCnt < 20) begin
      stepCycle();
      waitCnt++;
    end
    checkOutput("ready_before_accept", 32'(vecReady), 32'd1);
    stepCycle();
    vecValid = 1'b0;
    latency = 0;
    while (chkValid !== 1'b1 && latency < 20) begin
      stepCycle();
      latency++;
    end
    checkOutput("chk_valid_seen", 32'(chkValid), 32'd1);
  endtask

  task automatic doReset();
    reset = 1'b1; vecValid = 1'b0; termValid = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  initial begin
    int         lat;
    int         pulses;
    int         expFail;
    logic       readyAfterDone;
    logic [3:0] xv;
    logic [4:0] m;

    reset = 1'b1; vecValid = 1'b0; termValid = 1'b0;
    vec = '0; specO = '0; implO = '0;
    stepCycle();
    stepCycle();
    checkOutput("rst_vec_ready", 32'(vecReady), 32'd0);
    checkOutput("rst_chk_valid", 32'(chkValid), 32'd0);
    checkOutput("rst_chk_ok", 32'(chkOk), 32'd0);
    checkOutput("rst_chk_mask", 32'(chkMask), 32'd0);
    checkOutput("rst_vec_cnt", vecCnt, 32'd0);
    checkOutput("rst_fail_cnt", failCnt, 32'd0);
    checkOutput("rst_ff_vec", 32'(firstFailVec), 32'd0);
    checkOutput("rst_ff_mask", 32'(firstFailMask), 32'd0);
    checkOutput("rst_any_fail", 32'(anyFail), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("ready_after_reset", 32'(vecReady), 32'd1);

    // Matching outputs with explicit cycle-by-cycle timing.
    vec = 12'hA5C; specO = 20'h12345; implO = 20'h12345; vecValid = 1'b1;
    stepCycle();
    checkOutput("match_ready_low_e0", 32'(vecReady), 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("match_ready_low_e2", 32'(vecReady), 32'd0);
    checkOutput("match_no_early_valid", 32'(chkValid), 32'd0);
    stepCycle();
    checkOutput("match_chk_valid", 32'(chkValid), 32'd1);
    checkOutput("match_chk_ok", 32'(chkOk), 32'd1);
    checkOutput("match_chk_mask", 32'(chkMask), 32'd0);
    checkOutput("match_vec_cnt", vecCnt, 32'd1);
    checkOutput("match_any_fail", 32'(anyFail), 32'd0);
    checkOutput("match_ready_back", 32'(vecReady), 32'd1);
    vecValid = 1'b0;
    stepCycle();
    checkOutput("match_single_pulse", 32'(chkValid), 32'd0);

    // o3 mismatch: spec 6 vs impl 7.
    applyStimulus(12'h3F0, 20'h12645, 20'h12745, lat);
    checkOutput("o3_latency", 32'(lat), 32'd3);
    checkOutput("o3_chk_ok", 32'(chkOk), 32'd0);
    checkOutput("o3_chk_mask", 32'(chkMask), 32'b00100);
    checkOutput("o3_fail_cnt", failCnt, 32'd1);
    checkOutput("o3_ff_vec", 32'(firstFailVec), 32'h3F0);
    checkOutput("o3_ff_mask", 32'(firstFailMask), 32'b00100);
    checkOutput("o3_any_fail", 32'(anyFail), 32'd1);
    checkOutput("o3_vec_cnt", vecCnt, 32'd2);

    // Unknown bit on o1 of one side only, then the same unknown on both sides.
    xv = 4'b10x0;
    m = expMask({16'h1234, xv}, 20'h12348);
    expFail = (m != '0) ? 2 : 1;
    applyStimulus(12'h111, {16'h1234, xv}, 20'h12348, lat);
    checkOutput("x_chk_mask", 32'(chkMask), 32'(m));
    checkOutput("x_chk_ok", 32'(chkOk), 32'(m == '0));
    checkOutput("x_fail_cnt", failCnt, 32'(expFail));
    applyStimulus(12'h222, {16'h1234, xv}, {16'h1234, xv}, lat);
    checkOutput("x_same_chk_ok", 32'(chkOk), 32'd1);
    checkOutput("x_same_chk_mask", 32'(chkMask), 32'd0);
    checkOutput("x_same_vec_cnt", vecCnt, 32'd4);
    checkOutput("x_ff_vec_kept", 32'(firstFailVec), 32'h3F0);

    // First-fail retention from a clean start.
    doReset();
    stepCycle();
    applyStimulus(12'h001, 20'h12345, 20'h12346, lat);
    checkOutput("ret1_chk_mask", 32'(chkMask), 32'b00001);
    applyStimulus(12'h002, 20'h12345, 20'h22345, lat);
    checkOutput("ret2_chk_mask", 32'(chkMask), 32'b10000);
    checkOutput("ret_fail_cnt", failCnt, 32'd2);
    checkOutput("ret_ff_vec", 32'(firstFailVec), 32'h001);
    checkOutput("ret_ff_mask", 32'(firstFailMask), 32'b00001);
    checkOutput("ret_vec_cnt", vecCnt, 32'd2);

    // Termination after three compares with valid held far beyond that.
    vec = 12'h0C3; specO = 20'h12345; implO = 20'h12345; termValid = 1'b1;
    pulses = 0;
    readyAfterDone = 1'b0;
    for (int c = 0; c < 30; c++) begin
      stepCycle();
      if (tChkValid === 1'b1) pulses++;
      if (tDone === 1'b1 && tVecReady !== 1'b0) readyAfterDone = 1'b1;
    end
    termValid = 1'b0;
    checkOutput("term_pulses", 32'(pulses), 32'd3);
    checkOutput("term_done", 32'(tDone), 32'd1);
    checkOutput("term_vec_cnt", tVecCnt, 32'd3);
    checkOutput("term_vec_ready", 32'(tVecReady), 32'd0);
    checkOutput("term_ready_after_done", 32'(readyAfterDone), 32'd0);
    checkOutput("term_chk_ok", 32'(tChkOk), 32'd1);
    checkOutput("term_chk_mask", 32'(tChkMask), 32'd0);
    checkOutput("term_fail_cnt", tFailCnt, 32'd0);
    checkOutput("term_any_fail", 32'(tAnyFail), 32'd0);
    checkOutput("term_ff_vec", 32'(tFirstFailVec), 32'd0);
    checkOutput("term_ff_mask", 32'(tFirstFailMask), 32'd0);
    checkOutput("main_not_done", 32'(done), 32'd0);

    // Reset one cycle after acceptance aborts the vector.
    vec = 12'h0AB; specO = 20'h12345; implO = 20'h54321; vecValid = 1'b1;
    checkOutput("abort_ready", 32'(vecReady), 32'd1);
    stepCycle();
    vecValid = 1'b0;
    reset = 1'b1;
    stepCycle();
    checkOutput("abort_vec_ready", 32'(vecReady), 32'd0);
    checkOutput("abort_chk_valid", 32'(chkValid), 32'd0);
    checkOutput("abort_vec_cnt", vecCnt, 32'd0);
    checkOutput("abort_fail_cnt", failCnt, 32'd0);
    checkOutput("abort_any_fail", 32'(anyFail), 32'd0);
    checkOutput("abort_ff_vec", 32'(firstFailVec), 32'd0);
    checkOutput("abort_ff_mask", 32'(firstFailMask), 32'd0);
    checkOutput("abort_chk_mask", 32'(chkMask), 32'd0);
    checkOutput("abort_term_done", 32'(tDone), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("abort_ready_back", 32'(vecReady), 32'd1);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      if (chkValid === 1'b1) pulses++;
    end
    checkOutput("abort_no_pulse", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
